msu_audio_sector_server: RTL and testbench
==========================================

MSU_AUDIO_SECTOR_SERVER -- requirements
Module: msu_audio_sector_server

Interface
REQ-001 clk  input  1  single clock; all logic on its rising edge.
REQ-002 reset_n  input  1  synchronous, active-low reset.
REQ-003 abort  input  1  level; cancels any transfer (driven from track_processing).
REQ-004 base_addr  input  32  byte address of the track file in memory.
REQ-005 track_size  input  32  track file length in bytes.
REQ-006 audio_req  input  1  level; fetch next sector.
REQ-007 audio_seek  input  1  level; fetch sector after a seek (handled identically to audio_req).
REQ-008 audio_sector  input  22  sector index, 1024 bytes per sector.
REQ-009 audio_ack  output  1  high for the whole sector transfer.
REQ-010 audio_download  output  1  high for the whole sector transfer.
REQ-011 audio_data_wr  output  1  one-cycle strobe per 16-bit word.
REQ-012 audio_data  output  16  word, valid while audio_data_wr=1.
REQ-013 mem_rd  output  1  read request level, held until mem_ready.
REQ-014 mem_addr  output  32  byte address, stable while mem_rd=1.
REQ-015 mem_ready  input  1  one-cycle pulse; mem_dout valid in that cycle.
REQ-016 mem_dout  input  16  read data.

Function
REQ-017 States: IDLE, ISSUE, WAIT, EMIT, DONE.
REQ-018 IDLE: when (audio_req|audio_seek)=1 and abort=0, latch audio_sector, clear word_cnt (9 bits), go ISSUE; audio_ack and audio_download are 1 from the next cycle until DONE.
REQ-019 Word byte offset off = {sector,10'b0} + {word_cnt,1'b0}, 32-bit unsigned.
REQ-020 ISSUE: if off < track_size, drive mem_rd=1, mem_addr=base_addr+off (mod 2^32), go WAIT; otherwise load 16'h0000 into the output register and go EMIT with no memory access.
REQ-021 WAIT: hold mem_rd and mem_addr; on mem_ready capture mem_dout, drop mem_rd the next cycle, go EMIT.
REQ-022 EMIT: assert audio_data_wr for exactly one cycle with the captured word; if word_cnt=511 go DONE, else increment word_cnt and go ISSUE.
REQ-023 Word order is ascending address; each sector is exactly 512 strobes; audio_data_wr never occurs while audio_download=0.
REQ-024 Minimum spacing between strobes is 2 cycles (EMIT to ISSUE to EMIT for zero-fill words).
REQ-025 DONE: audio_ack=0, audio_download=0 for at least one cycle; request inputs are ignored in DONE; go IDLE.
REQ-026 audio_req/audio_seek and audio_sector changes outside IDLE are ignored.
REQ-027 abort=1 in any state: next cycle all outputs 0, state IDLE, word_cnt 0; no strobe in that cycle. An outstanding mem_ready arriving after abort is discarded.
REQ-028 abort and a request in the same cycle: abort wins.
REQ-029 Partial last sector: words whose off >= track_size are zero-filled; a sector entirely beyond track_size yields 512 zero words.

Reset
REQ-030 With reset_n=0 at a clock edge: state IDLE, word_cnt 0; audio_ack, audio_download, audio_data_wr, mem_rd all 0; audio_data and mem_addr 0.
REQ-031 Reset mid-transfer behaves as abort; reset takes priority over abort and requests.

Verification
REQ-032 base_addr=0x1000, track_size=0x10000, seek with sector=0, memory returns addr[15:0] after 3 cycles -> ack/download high for the transfer, 512 strobes with data 0x1000,0x1002,...,0x13FE, then ack low for at least one cycle.
REQ-033 track_size=0x0C08, req with sector=3 -> 4 strobes with memory data (addresses base+0xC00..0xC06), then 508 strobes of 0x0000 with mem_rd never asserted.
REQ-034 Request with sector=5, track_size=0x400 -> 512 zero words, mem_rd stays 0, strobes spaced exactly 2 cycles apart.
REQ-035 abort after word 100 while mem_rd=1 -> next cycle ack/download/mem_rd=0; a late mem_ready produces no strobe; a new req then restarts at word 0.
REQ-036 req held high across a full transfer -> second transfer starts only after at least one cycle with ack=0 and download=0.
REQ-037 base_addr=0xFFFFFE00, sector=0 -> mem_addr wraps from 0xFFFFFFFE to 0x00000000 at word 256.

Source files
------------

// File: rtl/msu_audio_sector_server_if.sv
// Memory read port of the MSU audio sector server: level request held
// until a one-cycle ready pulse that carries the read word.
interface msu_audio_sector_server_if;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_dout;

  modport master (output mem_rd, mem_addr, input mem_ready, mem_dout);
  modport slave  (input mem_rd, mem_addr, output mem_ready, mem_dout);
endinterface

// File: rtl/msu_audio_sector_server.sv
// Streams one 1024-byte audio sector as 512 16-bit words from memory,
// zero-filling any word that lies at or beyond the end of the track file.
module msu_audio_sector_server (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        abort,
  input  logic [31:0] base_addr,
  input  logic [31:0] track_size,
  input  logic        audio_req,
  input  logic        audio_seek,
  input  logic [21:0] audio_sector,
  output logic        audio_ack,
  output logic        audio_download,
  output logic        audio_data_wr,
  output logic [15:0] audio_data,
  msu_audio_sector_server_if.master mem
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [21:0] sector_q;
  logic [8:0]  word_cnt;
  logic [31:0] off;
  logic        in_range;
  logic        start;

  assign off      = {sector_q, 10'b0} + {22'd0, word_cnt, 1'b0};
  assign in_range = off < track_size;
  assign start    = (audio_req | audio_seek) & ~abort;

  // Handshake outputs are pure decodes of the state register.
  assign audio_ack      = (state == ISSUE) || (state == WAIT) || (state == EMIT);
  assign audio_download = audio_ack;
  assign audio_data_wr  = (state == EMIT);

  // NOTE: reset is synchronous here, so it lives inside the clocked branch
  // and is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: next state defaults to the current state first so no path through
  // the case statement leaves it unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: state_nxt = in_range ? WAIT : EMIT;
      WAIT:  if (mem.mem_ready) state_nxt = EMIT;
      EMIT:  state_nxt = (word_cnt == 9'd511) ? DONE : ISSUE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || abort) begin
      sector_q     <= '0;
      word_cnt     <= '0;
      audio_data   <= '0;
      mem.mem_rd   <= 1'b0;
      mem.mem_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sector_q <= audio_sector;
            word_cnt <= '0;
          end
        end
        ISSUE: begin
          if (in_range) begin
            mem.mem_rd   <= 1'b1;
            mem.mem_addr <= base_addr + off;
          end else begin
            audio_data <= 16'h0000;
          end
        end
        WAIT: begin
          // A ready pulse that lands while idle (e.g. after an abort) never
          // reaches this branch, so it is silently dropped.
          if (mem.mem_ready) begin
            audio_data <= mem.mem_dout;
            mem.mem_rd <= 1'b0;
          end
        end
        EMIT: begin
          if (word_cnt != 9'd511) word_cnt <= word_cnt + 9'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msu_audio_sector_server.sv
// Randomised and directed bench for msu_audio_sector_server against a
// sector-level reference model and an addr[15:0]-echo memory.
module tb_msu_audio_sector_server;

  logic        clk = 1'b0;
  logic        reset_n, abort, audio_req, audio_seek;
  logic [31:0] base_addr, track_size;
  logic [21:0] audio_sector;
  logic        audio_ack, audio_download, audio_data_wr;
  logic [15:0] audio_data;

  msu_audio_sector_server_if mif();

  msu_audio_sector_server dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .abort          (abort),
    .base_addr      (base_addr),
    .track_size     (track_size),
    .audio_req      (audio_req),
    .audio_seek     (audio_seek),
    .audio_sector   (audio_sector),
    .audio_ack      (audio_ack),
    .audio_download (audio_download),
    .audio_data_wr  (audio_data_wr),
    .audio_data     (audio_data),
    .mem            (mif.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory: returns addr[15:0] mem_lat cycles after it first sees mem_rd.
  int mem_lat = 3;
  initial begin
    logic [31:0] a;
    mif.mem_ready = 1'b0;
    mif.mem_dout  = 16'h0;
    forever begin
      @(negedge clk);
      if (mif.mem_rd === 1'b1) begin
        a = mif.mem_addr;
        repeat (mem_lat - 1) @(negedge clk);
        mif.mem_ready = 1'b1;
        mif.mem_dout  = a[15:0];
        @(negedge clk);
        mif.mem_ready = 1'b0;
        mif.mem_dout  = 16'($urandom);
      end
    end
  end

  // Monitor: records strobes, read addresses and protocol violations.
  logic [15:0] strobes[$];
  logic [31:0] rd_addrs[$];
  int          strobe_cyc[$];
  int          cyc = 0;
  int          wr_outside = 0;
  int          addr_unstable = 0;
  logic        prev_rd = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    cyc++;
    if (audio_data_wr === 1'b1) begin
      strobes.push_back(audio_data);
      strobe_cyc.push_back(cyc);
      if (audio_download !== 1'b1) wr_outside++;
    end
    if (mif.mem_rd === 1'b1 && !prev_rd) rd_addrs.push_back(mif.mem_addr);
    if (mif.mem_rd === 1'b1 && prev_rd && mif.mem_addr !== prev_addr) addr_unstable++;
    prev_rd   = (mif.mem_rd === 1'b1);
    prev_addr = mif.mem_addr;
  end

  task automatic clear_mon();
    strobes.delete();
    rd_addrs.delete();
    strobe_cyc.delete();
    wr_outside    = 0;
    addr_unstable = 0;
  endtask

  task automatic wait_ack(input logic lvl, input int budget, input string tag);
    int waited = 0;
    while (audio_ack !== lvl && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (audio_ack !== lvl) check({tag, "_timeout"}, 32'(audio_ack), 32'(lvl));
  endtask

  // Reference: word w lives at byte offset sector*1024 + 2w; inside the
  // track it is read from base+offset, beyond it the word is zero.
  task automatic check_xfer(input string tag, input logic [31:0] base,
                            input logic [31:0] size, input logic [21:0] sec);
    logic [31:0] off, a;
    logic [15:0] exp_words[$];
    logic [31:0] exp_addrs[$];
    int gap_short = 0;
    int gap_not2  = 0;
    for (int w = 0; w < 512; w++) begin
      off = {sec, 10'b0} + 32'(2 * w);
      if (off < size) begin
        a = base + off;
        exp_addrs.push_back(a);
        exp_words.push_back(a[15:0]);
      end else begin
        exp_words.push_back(16'h0000);
      end
    end
    check({tag, "_nstrobes"}, 32'(strobes.size()), 32'd512);
    check({tag, "_nreads"}, 32'(rd_addrs.size()), 32'(exp_addrs.size()));
    for (int i = 0; i < strobes.size() && i < 512; i++)
      check($sformatf("%s_word%0d", tag, i), 32'(strobes[i]), 32'(exp_words[i]));
    for (int i = 0; i < rd_addrs.size() && i < exp_addrs.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), rd_addrs[i], exp_addrs[i]);
    for (int i = 1; i < strobe_cyc.size(); i++) begin
      if (strobe_cyc[i] - strobe_cyc[i-1] < 2) gap_short++;
      if (strobe_cyc[i] - strobe_cyc[i-1] != 2) gap_not2++;
    end
    check({tag, "_gap_min2"}, 32'(gap_short), 32'd0);
    if (exp_addrs.size() == 0) check({tag, "_gap_zero_fill"}, 32'(gap_not2), 32'd0);
    check({tag, "_wr_outside_dl"}, 32'(wr_outside), 32'd0);
    check({tag, "_addr_stable"}, 32'(addr_unstable), 32'd0);
  endtask

  task automatic start_xfer(input logic [31:0] base, input logic [31:0] size,
                            input logic [21:0] sec, input int lat, input bit seek);
    base_addr    = base;
    track_size   = size;
    audio_sector = sec;
    mem_lat      = lat;
    clear_mon();
    @(negedge clk);
    if (seek) audio_seek = 1'b1;
    else      audio_req  = 1'b1;
    @(negedge clk);
    audio_req    = 1'b0;
    audio_seek   = 1'b0;
    audio_sector = 22'($urandom);
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] base, input logic [31:0] size,
                          input logic [21:0] sec, input int lat, input bit seek);
    start_xfer(base, size, sec, lat, seek);
    check({tag, "_ack_on"}, 32'(audio_ack), 32'd1);
    check({tag, "_dl_on"}, 32'(audio_download), 32'd1);
    wait_ack(1'b0, 512 * (lat + 4) + 64, tag);
    check({tag, "_dl_off"}, 32'(audio_download), 32'd0);
    check_xfer(tag, base, size, sec);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ack"}, 32'(audio_ack), 32'd0);
    check({tag, "_dl"}, 32'(audio_download), 32'd0);
    check({tag, "_wr"}, 32'(audio_data_wr), 32'd0);
    check({tag, "_rd"}, 32'(mif.mem_rd), 32'd0);
    check({tag, "_data"}, 32'(audio_data), 32'd0);
    check({tag, "_addr"}, mif.mem_addr, 32'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int lowc;
    int dl_bad;
    logic [31:0] b, s;
    logic [21:0] sec;

    reset_n = 1'b0; abort = 1'b0; audio_req = 1'b0; audio_seek = 1'b0;
    base_addr = '0; track_size = '0; audio_sector = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset_n = 1'b1;
    @(negedge clk);

    run_xfer("r032", 32'h0000_1000, 32'h0001_0000, 22'd0, 3, 1'b1);
    run_xfer("r033", 32'h0004_0000, 32'h0000_0C08, 22'd3, 2, 1'b0);
    run_xfer("r034", 32'h0123_4560, 32'h0000_0400, 22'd5, 3, 1'b0);

    // Wrap of the byte address at the top of memory.
    run_xfer("r037", 32'hFFFF_FE00, 32'h0001_0000, 22'd0, 1, 1'b0);
    if (rd_addrs.size() > 256) begin
      check("r037_before_wrap", rd_addrs[255], 32'hFFFF_FFFE);
      check("r037_wrap", rd_addrs[256], 32'h0000_0000);
    end else begin
      check("r037_nreads_short", 32'(rd_addrs.size()), 32'd512);
    end

    // Abort while the read for word 100 is outstanding.
    start_xfer(32'h0002_0000, 32'h0010_0000, 22'd2, 3, 1'b0);
    waited = 0;
    while (!(strobes.size() == 100 && mif.mem_rd === 1'b1) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("r035_reach_word100", 32'(strobes.size()), 32'd100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_quiet("r035_abort");
    repeat (8) @(negedge clk);
    check("r035_late_ready", 32'(strobes.size()), 32'd100);
    run_xfer("r035_restart", 32'h0002_0000, 32'h0010_0000, 22'd2, 3, 1'b0);

    // Abort and request in the same cycle: abort wins.
    audio_req = 1'b1; abort = 1'b1;
    @(negedge clk);
    audio_req = 1'b0; abort = 1'b0;
    check("r028_ack", 32'(audio_ack), 32'd0);
    @(negedge clk);
    check("r028_ack_after", 32'(audio_ack), 32'd0);

    // Request held across a whole transfer.
    base_addr = 32'h0000_8000; track_size = 32'h0000_2000; audio_sector = 22'd1; mem_lat = 2;
    clear_mon();
    audio_req = 1'b1;
    wait_ack(1'b1, 4, "r036_first");
    wait_ack(1'b0, 512 * 6 + 64, "r036_first_end");
    lowc = 0; dl_bad = 0;
    while (audio_ack !== 1'b1 && lowc < 10) begin
      if (audio_download !== 1'b0) dl_bad++;
      @(negedge clk);
      lowc++;
    end
    check("r036_gap_ge1", 32'(lowc >= 1), 32'd1);
    check("r036_dl_low", 32'(dl_bad), 32'd0);
    check("r036_second_start", 32'(audio_ack), 32'd1);
    check_xfer("r036_first", 32'h0000_8000, 32'h0000_2000, 22'd1);
    clear_mon();
    audio_req = 1'b0;
    wait_ack(1'b0, 512 * 6 + 64, "r036_second_end");
    check_xfer("r036_second", 32'h0000_8000, 32'h0000_2000, 22'd1);
    repeat (2) @(negedge clk);

    // Reset in the middle of a transfer.
    start_xfer(32'h0003_0000, 32'h0010_0000, 22'd7, 2, 1'b1);
    waited = 0;
    while (strobes.size() < 20 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_quiet("r031_reset_mid");
    repeat (8) @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      b   = $urandom;
      sec = 22'($urandom_range(0, 63));
      s   = {sec, 10'b0} + 32'($urandom_range(0, 1100));
      run_xfer($sformatf("rand%0d", k), b, s, sec, int'($urandom_range(1, 3)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
